// File: rtl/block_stepper_pkg.sv
// Shared encodings for the block stepper: FSM states and travel directions.
package block_stepper_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/block_stepper_rise_detect.sv
// Rising-edge detector for a level sampled in the sys_clk domain.
// The history register resets high so an input already high at reset release gives no edge.
module rise_detect (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) in_q <= 1'b1;
    else         in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/block_stepper.sv
// Turns rising edges of the divided block clock (or manual step requests while stopped)
// into position steps with wrap or bounce travel.
module block_stepper
  import block_stepper_pkg::*;
#(
  parameter  int POS_COUNT = 8,
  parameter  int RESET_POS = 0,
  localparam int PW        = $clog2(POS_COUNT)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          block_clk,
  input  logic          run_en,
  input  logic          step_btn,
  input  logic          bounce_mode,
  input  logic          dir_in,
  output logic [PW-1:0] pos_out,
  output logic          dir_out,
  output logic          step_tick,
  output logic          end_pulse,
  output logic          running
);

  localparam logic [PW-1:0] P_MAX = PW'(POS_COUNT - 1);
  localparam logic [PW-1:0] P_MIN = '0;
  localparam logic [PW-1:0] P_RST = PW'(RESET_POS);
  localparam logic [PW-1:0] P_ONE = PW'(1);

  logic          clk_rise, step_rise;
  state_e        state_q, state_nxt;
  logic          adv, ed, end_evt, dir_nxt;
  logic [PW-1:0] pos_nxt;

  rise_detect u_clk_rise (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in      (block_clk),
    .rise    (clk_rise)
  );

  rise_detect u_step_rise (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .in      (step_btn),
    .rise    (step_rise)
  );

  // Advance is decided on the current state; unused edges are simply dropped.
  always_comb begin
    state_nxt = run_en ? ST_RUNNING : ST_STOPPED;
    adv       = (state_q == ST_RUNNING) ? clk_rise : step_rise;
    ed        = bounce_mode ? dir_out : dir_in;
    pos_nxt   = pos_out;
    dir_nxt   = ed;
    end_evt   = 1'b0;
    if (adv) begin
      if (ed == DIR_UP) begin
        if (pos_out == P_MAX) begin
          end_evt = 1'b1;
          if (bounce_mode) begin
            pos_nxt = P_MAX - P_ONE;
            dir_nxt = DIR_DOWN;
          end else begin
            pos_nxt = P_MIN;
          end
        end else begin
          pos_nxt = pos_out + P_ONE;
        end
      end else begin
        if (pos_out == P_MIN) begin
          end_evt = 1'b1;
          if (bounce_mode) begin
            pos_nxt = P_MIN + P_ONE;
            dir_nxt = DIR_UP;
          end else begin
            pos_nxt = P_MAX;
          end
        end else begin
          pos_nxt = pos_out - P_ONE;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_STOPPED;
      pos_out   <= P_RST;
      dir_out   <= DIR_UP;
      step_tick <= 1'b0;
      end_pulse <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pos_out   <= pos_nxt;
      dir_out   <= dir_nxt;
      step_tick <= adv;
      end_pulse <= adv & end_evt;
    end
  end

  assign running = (state_q == ST_RUNNING);

endmodule
